// File: rtl/raster_cmd_queue_pkg.sv
// Shared types for the raster command path: opcodes, argument bundle,
// FIFO entry layout, framebuffer limits and the issuer FSM states.
package common;

  typedef enum logic [2:0] {
    RASTER_CMD_NOP   = 3'd0,
    RASTER_CMD_FILL  = 3'd1,
    RASTER_CMD_LINE  = 3'd2,
    RASTER_CMD_RECT  = 3'd3,
    RASTER_CMD_CLEAR = 3'd4
  } raster_command_t;

  typedef struct packed {
    logic [2:0] colour;
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
  } raster_args_t;

  typedef struct packed {
    raster_command_t command;
    raster_args_t    args;
  } raster_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } queue_state_t;

  localparam int FB_WIDTH  = 214;
  localparam int FB_HEIGHT = 160;

  localparam logic [7:0] X_MAX = 8'(FB_WIDTH - 1);
  localparam logic [7:0] Y_MAX = 8'(FB_HEIGHT - 1);

  // Saturate a coordinate to the last valid pixel index.
  function automatic logic [7:0] clamp_coord(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/raster_cmd_queue_fifo.sv
// Synchronous FIFO of raster command entries. Occupancy is tracked with an
// explicit level counter so full/empty never depend on pointer equality.
// A push while full is accepted only when a pop happens on the same edge.
module raster_cmd_fifo
  import common::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_async,
  input  logic                     push,
  input  logic                     pop,
  input  raster_entry_t            wr_data,
  output raster_entry_t            rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;
  raster_entry_t mem_q [DEPTH];

  // Qualify requests and compute next pointers / occupancy.
  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LVL_FULL) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);

endmodule

// File: rtl/raster_cmd_queue.sv
// Raster command issuer: buffers CPU commands and hands them one at a time
// to the rasterizer over the execute_request / raster_busy handshake.
// Build option: RASTER_CMD_QUEUE_CLIP_EN clamps coordinates on push.
//
// state         | meaning
// ST_IDLE       | waiting for a queued command and rasterizer not busy; pops on exit
// ST_ISSUE      | execute_request high for this single cycle
// ST_WAIT_START | waiting for the rasterizer to raise raster_busy
// ST_WAIT_DONE  | waiting for raster_busy to fall
module raster_cmd_queue
  import common::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_async,
  input  logic                   cpu_push,
  input  raster_command_t        cpu_command,
  input  logic [2:0]             cpu_colour,
  input  logic [7:0]             cpu_x0,
  input  logic [7:0]             cpu_y0,
  input  logic [7:0]             cpu_x1,
  input  logic [7:0]             cpu_y1,
  input  logic                   cpu_clear_overflow,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   idle,
  output raster_command_t        command,
  output logic [2:0]             colour,
  output logic [7:0]             x0,
  output logic [7:0]             y0,
  output logic [7:0]             x1,
  output logic [7:0]             y1,
  output logic                   execute_request,
  input  logic                   raster_busy
);

  queue_state_t  state_q, state_d;
  raster_entry_t entry_q, entry_d;
  raster_entry_t wr_entry, rd_entry;
  logic          overflow_q, overflow_d;
  logic          pop;

  // Build the entry to store, optionally clamped to the framebuffer.
  always_comb begin
    wr_entry.command     = cpu_command;
    wr_entry.args.colour = cpu_colour;
`ifdef RASTER_CMD_QUEUE_CLIP_EN
    wr_entry.args.x0 = clamp_coord(cpu_x0, X_MAX);
    wr_entry.args.y0 = clamp_coord(cpu_y0, Y_MAX);
    wr_entry.args.x1 = clamp_coord(cpu_x1, X_MAX);
    wr_entry.args.y1 = clamp_coord(cpu_y1, Y_MAX);
`else
    wr_entry.args.x0 = cpu_x0;
    wr_entry.args.y0 = cpu_y0;
    wr_entry.args.x1 = cpu_x1;
    wr_entry.args.y1 = cpu_y1;
`endif
  end

  raster_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_async (rst_async),
    .push      (cpu_push),
    .pop       (pop),
    .wr_data   (wr_entry),
    .rd_data   (rd_entry),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Issuer FSM next-state, pop and strobe decode.
  always_comb begin
    state_d         = state_q;
    pop             = 1'b0;
    execute_request = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !raster_busy) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        execute_request = 1'b1;
        state_d         = ST_WAIT_START;
      end
      ST_WAIT_START: if (raster_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE:  if (!raster_busy) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Argument latch on pop; sticky overflow where a drop beats a clear.
  always_comb begin
    entry_d    = pop ? rd_entry : entry_q;
    overflow_d = overflow_q;
    if (cpu_clear_overflow) overflow_d = 1'b0;
    if (cpu_push && full && !pop) overflow_d = 1'b1;
  end

  // State, argument and flag registers.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q    <= ST_IDLE;
      entry_q    <= '{command: RASTER_CMD_NOP, args: '0};
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      overflow_q <= overflow_d;
    end
  end

  assign command  = entry_q.command;
  assign colour   = entry_q.args.colour;
  assign x0       = entry_q.args.x0;
  assign y0       = entry_q.args.y0;
  assign x1       = entry_q.args.x1;
  assign y1       = entry_q.args.y1;
  assign overflow = overflow_q;
  assign idle     = empty && (state_q == ST_IDLE) && !raster_busy;

endmodule
